pcie_cq_type_stats: RTL and testbench
=====================================

Name: pcie_cq_type_stats

Overview:
Parametrised successor to the fixed 8-bit CQ type counter. Sits transparently on the PCIe Completer reQuest AXI-stream, between the hard block and user logic.
- Counts accepted TLPs per request type (16 types) with configurable counter width and saturate/wrap mode.
- Tracks packet framing with a small FSM and counts framing errors, beats and backpressure stalls.
- Provides atomic snapshot and read-and-clear so software/ILA reads a coherent set.

Parameters:
AXIS_DATA_WIDTH, 512, stream data width
AXIS_TUSER_WIDTH, 229, stream tuser width
CNT_WIDTH, 32, width of every statistics counter (2..64)
SATURATE, 1, 1 = counters stick at all-ones; 0 = wrap to 0
TYPE_LSB, 75, LSB of 4-bit request type field in tdata at SOP beat
SOP_MODE, 0, 0 = SOP from tuser[SOP_LSB+1:SOP_LSB]!=0; 1 = SOP derived from framing FSM (first beat after tlast)
SOP_LSB, 80, LSB of 2-bit SOP field in tuser (SOP_MODE 0 only)
DWCNT_LSB, 64, LSB of 11-bit dword-count field in tdata at SOP beat

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_tdata/tkeep/tvalid/tlast/tuser  in  widths per params  CQ stream from PCIe
s_axis_tready  out  1  = m_axis_tready (combinational)
m_axis_tdata/tkeep/tvalid/tlast/tuser  out  widths per params  combinational copy of s_axis_*
m_axis_tready  in  1  from user logic
clear_req  in  1  pulse: clear all live counters
snap_req  in  1  pulse: copy live counters into snapshot registers
cnt_type  out  16*CNT_WIDTH  live per-type counters, type t at [t*CNT_WIDTH +: CNT_WIDTH]
snap_type  out  16*CNT_WIDTH  snapshot of cnt_type
cnt_pkt_total  out  CNT_WIDTH  all counted packets
cnt_beats  out  CNT_WIDTH  accepted beats (tvalid&tready)
cnt_stall  out  CNT_WIDTH  cycles with tvalid&!tready
cnt_proto_err  out  CNT_WIDTH  framing errors
snap_valid  out  1  one-cycle pulse, snapshot updated
dw_mem_write  out  CNT_WIDTH  dwords in memory-write TLPs (see Optional Feature)

Behaviour:
- Datapath purely combinational; zero latency, no buffering, never alters handshake.
- beat = s_axis_tvalid & s_axis_tready. All counters registered: update on the clk edge after the qualifying cycle.
- Reset: all counters, snapshot regs, dw_mem_write = 0; snap_valid = 0; FSM = IDLE. Reset mid-packet discards framing state; the next beat is judged from IDLE.
- Framing FSM, advances only on beat:
  - IDLE: SOP beat -> count packet; go IN_PKT if !tlast, else stay IDLE.
  - IDLE: non-SOP beat (SOP_MODE 0 only) -> cnt_proto_err+1, packet not counted, stay IDLE.
  - IN_PKT: tlast -> IDLE.
  - IN_PKT: SOP beat (SOP_MODE 0) -> cnt_proto_err+1, counted as new packet; stay IN_PKT unless tlast.
- SOP_MODE 1: every beat in IDLE is SOP; no errors generated.
- Packet count: cnt_type[req_type]+1 and cnt_pkt_total+1, with req_type = tdata[TYPE_LSB+3:TYPE_LSB]. Straddle (sop=2'b11) is counted once, using the first TLP's type.
- Increment rule: SATURATE=1: no change at all-ones. SATURATE=0: all-ones+1 = 0.
- clear_req: each live counter loads 0+inc of this cycle's event, so coincident events are not lost.
- snap_req: snapshot takes pre-clear live values (value before this edge's update); snap_valid pulses the next cycle.
- snap_req and clear_req together = atomic read-and-clear.
- Snapshot covers cnt_type only.

Optional Feature:
PCIE_CQ_STATS_DWORD_EN
- Defined: on each counted packet with req_type 4'b0001, dw_mem_write += tdata[DWCNT_LSB+10:DWCNT_LSB], where 11'd0 means 1024. Follows the SATURATE rule and clear_req; reset 0.
- Undefined: dw_mem_write tied to 0, no adder synthesised.

Test Plan:
1. Reset, then single-beat SOP+tlast TLPs of types 0,1,1,8 -> cnt_type[0]=1, [1]=2, [8]=1, cnt_pkt_total=4, cnt_beats=4, cnt_proto_err=0.
2. 3-beat memwrite with m_axis_tready low 5 cycles mid-packet -> cnt_type[1]=1, cnt_beats=3, cnt_stall=5, m_axis mirrors s_axis every cycle.
3. CNT_WIDTH=4, SATURATE=1: 20 type-0 packets -> cnt_type[0]=15. Same with SATURATE=0 -> cnt_type[0]=4.
4. SOP_MODE 0: non-SOP beat in IDLE, then SOP without tlast followed by another SOP -> cnt_proto_err=2, cnt_pkt_total=2.
5. cnt_type[2]=7; assert snap_req+clear_req together with a type-2 SOP beat -> snap_type[2]=7, cnt_type[2]=1, snap_valid high exactly one cycle.
6. With PCIE_CQ_STATS_DWORD_EN defined: memwrites with dword count 4 and 0 -> dw_mem_write=1028. Without the macro -> dw_mem_write=0.

Source files
------------

// File: rtl/pcie_cq_type_stats.sv
// Transparent statistics tap on the PCIe CQ AXI-stream: per-type TLP counters, framing checks,
// snapshot/read-and-clear. Optional macro PCIE_CQ_STATS_DWORD_EN adds the memory-write dword total.
module pcie_cq_type_stats #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 229,
  parameter int CNT_WIDTH        = 32,
  parameter int SATURATE         = 1,
  parameter int TYPE_LSB         = 75,
  parameter int SOP_MODE         = 0,
  parameter int SOP_LSB          = 80,
  parameter int DWCNT_LSB        = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/32-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  output logic                          s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/32-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  input  logic                          m_axis_tready,
  input  logic                          clear_req,
  input  logic                          snap_req,
  output logic [16*CNT_WIDTH-1:0]       cnt_type,
  output logic [16*CNT_WIDTH-1:0]       snap_type,
  output logic [CNT_WIDTH-1:0]          cnt_pkt_total,
  output logic [CNT_WIDTH-1:0]          cnt_beats,
  output logic [CNT_WIDTH-1:0]          cnt_stall,
  output logic [CNT_WIDTH-1:0]          cnt_proto_err,
  output logic                          snap_valid,
  output logic [CNT_WIDTH-1:0]          dw_mem_write
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t               state_reg;
  logic                 beat;
  logic                 sop;
  logic                 pkt_evt;
  logic                 err_evt;
  logic                 stall_evt;
  logic [3:0]           req_type;
  logic [CNT_WIDTH-1:0] total_reg, beats_reg, stall_reg, err_reg;
  logic                 snap_valid_reg;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser;
  assign s_axis_tready = m_axis_tready;

  assign beat      = s_axis_tvalid & m_axis_tready;
  assign stall_evt = s_axis_tvalid & ~m_axis_tready;
  assign req_type  = s_axis_tdata[TYPE_LSB +: 4];

  generate
    if (SOP_MODE == 1) begin : g_sop_fsm
      assign sop = (state_reg == IDLE);
    end else begin : g_sop_tuser
      assign sop = |s_axis_tuser[SOP_LSB +: 2];
    end
  endgenerate

  // A straddled beat (sop=2'b11) is one packet event; its type field belongs to the first TLP.
  assign pkt_evt = beat & sop;
  assign err_evt = (SOP_MODE == 0) & beat &
                   (((state_reg == IDLE) & ~sop) | ((state_reg == IN_PKT) & sop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else if (beat) begin
      if (s_axis_tlast)
        state_reg <= IDLE;
      else if (sop || state_reg == IN_PKT)
        state_reg <= IN_PKT;
      else
        state_reg <= IDLE;
    end
  end

  // Clear zeroes the base but still applies this cycle's increment, so no event is lost.
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] cur,
                                                input logic inc, input logic clr);
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (inc && !((SATURATE != 0) && (&base)))
      base = base + CNT_WIDTH'(1);
    return base;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_type
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] snap_reg;
      logic                 hit;

      assign hit = pkt_evt && (req_type == 4'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          snap_reg <= '0;
        end else begin
          cnt_reg <= bump(cnt_reg, hit, clear_req);
          if (snap_req)
            snap_reg <= cnt_reg;
        end
      end

      assign cnt_type[gi*CNT_WIDTH +: CNT_WIDTH]  = cnt_reg;
      assign snap_type[gi*CNT_WIDTH +: CNT_WIDTH] = snap_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      total_reg      <= '0;
      beats_reg      <= '0;
      stall_reg      <= '0;
      err_reg        <= '0;
      snap_valid_reg <= 1'b0;
    end else begin
      total_reg      <= bump(total_reg, pkt_evt, clear_req);
      beats_reg      <= bump(beats_reg, beat, clear_req);
      stall_reg      <= bump(stall_reg, stall_evt, clear_req);
      err_reg        <= bump(err_reg, err_evt, clear_req);
      snap_valid_reg <= snap_req;
    end
  end

  assign cnt_pkt_total = total_reg;
  assign cnt_beats     = beats_reg;
  assign cnt_stall     = stall_reg;
  assign cnt_proto_err = err_reg;
  assign snap_valid    = snap_valid_reg;

`ifdef PCIE_CQ_STATS_DWORD_EN
  localparam int SUM_W = ((CNT_WIDTH > 11) ? CNT_WIDTH : 11) + 1;

  logic [CNT_WIDTH-1:0] dw_reg;
  logic [CNT_WIDTH-1:0] dw_next;
  logic [CNT_WIDTH-1:0] dw_base;
  logic [10:0]          dw_amt;
  logic [SUM_W-1:0]     dw_sum;
  logic                 dw_evt;

  assign dw_evt = pkt_evt & (req_type == 4'b0001);

  always_comb begin
    dw_amt  = s_axis_tdata[DWCNT_LSB +: 11];
    if (dw_amt == 11'd0)
      dw_amt = 11'd1024;
    dw_base = clear_req ? '0 : dw_reg;
    dw_sum  = SUM_W'(dw_base) + SUM_W'(dw_amt);
    dw_next = dw_base;
    if (dw_evt) begin
      // Anything above CNT_WIDTH bits means the running total overflowed.
      if ((SATURATE != 0) && (|dw_sum[SUM_W-1:CNT_WIDTH]))
        dw_next = '1;
      else
        dw_next = dw_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      dw_reg <= '0;
    else
      dw_reg <= dw_next;
  end

  assign dw_mem_write = dw_reg;
`else
  assign dw_mem_write = '0;
`endif

endmodule

// File: tb/tb_pcie_cq_type_stats.sv
// Directed, table-driven bench for pcie_cq_type_stats: a 32-bit saturating instance, two 4-bit
// instances (saturate / wrap) and a SOP_MODE 1 instance, all fed from one stimulus stream.
module tb_pcie_cq_type_stats;

  logic         clk;
  logic         rst;
  logic [511:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tvalid;
  logic         s_tlast;
  logic [228:0] s_tuser;
  logic         m_tready;
  logic         clear_req;
  logic         snap_req;

  // main instance (defaults)
  logic         tready;
  logic [511:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic [228:0] m_tuser;
  logic [511:0] cnt_type, snap_type;
  logic [31:0]  total, beats, stall, err, dw;
  logic         snap_valid;

  // 4-bit saturating, 4-bit wrapping, SOP_MODE 1
  logic         sat_tready, wrp_tready, md1_tready;
  logic [511:0] sat_tdata, wrp_tdata, md1_tdata;
  logic [15:0]  sat_tkeep, wrp_tkeep, md1_tkeep;
  logic         sat_tvalid, wrp_tvalid, md1_tvalid;
  logic         sat_tlast, wrp_tlast, md1_tlast;
  logic [228:0] sat_tuser, wrp_tuser, md1_tuser;
  logic [63:0]  sat_cnt_type, sat_snap_type, wrp_cnt_type, wrp_snap_type;
  logic [3:0]   sat_total, sat_beats, sat_stall, sat_err, sat_dw;
  logic [3:0]   wrp_total, wrp_beats, wrp_stall, wrp_err, wrp_dw;
  logic         sat_snap_valid, wrp_snap_valid, md1_snap_valid;
  logic [511:0] md1_cnt_type, md1_snap_type;
  logic [31:0]  md1_total, md1_beats, md1_stall, md1_err, md1_dw;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PCIE_CQ_STATS_DWORD_EN
  localparam logic [63:0] EXP_DW      = 64'd1028;
  localparam logic [63:0] EXP_DW_CLR  = 64'd5;
  localparam logic [63:0] EXP_DW_SAT4 = 64'd15;
  localparam logic [63:0] EXP_DW_WRP4 = 64'd4;
`else
  localparam logic [63:0] EXP_DW      = 64'd0;
  localparam logic [63:0] EXP_DW_CLR  = 64'd0;
  localparam logic [63:0] EXP_DW_SAT4 = 64'd0;
  localparam logic [63:0] EXP_DW_WRP4 = 64'd0;
`endif

  pcie_cq_type_stats dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .clear_req(clear_req), .snap_req(snap_req),
    .cnt_type(cnt_type), .snap_type(snap_type), .cnt_pkt_total(total),
    .cnt_beats(beats), .cnt_stall(stall), .cnt_proto_err(err),
    .snap_valid(snap_valid), .dw_mem_write(dw)
  );

  pcie_cq_type_stats #(.CNT_WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(sat_tready),
    .m_axis_tdata(sat_tdata), .m_axis_tkeep(sat_tkeep), .m_axis_tvalid(sat_tvalid),
    .m_axis_tlast(sat_tlast), .m_axis_tuser(sat_tuser), .m_axis_tready(m_tready),
    .clear_req(clear_req), .snap_req(snap_req),
    .cnt_type(sat_cnt_type), .snap_type(sat_snap_type), .cnt_pkt_total(sat_total),
    .cnt_beats(sat_beats), .cnt_stall(sat_stall), .cnt_proto_err(sat_err),
    .snap_valid(sat_snap_valid), .dw_mem_write(sat_dw)
  );

  pcie_cq_type_stats #(.CNT_WIDTH(4), .SATURATE(0)) dut_wrp (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(wrp_tready),
    .m_axis_tdata(wrp_tdata), .m_axis_tkeep(wrp_tkeep), .m_axis_tvalid(wrp_tvalid),
    .m_axis_tlast(wrp_tlast), .m_axis_tuser(wrp_tuser), .m_axis_tready(m_tready),
    .clear_req(clear_req), .snap_req(snap_req),
    .cnt_type(wrp_cnt_type), .snap_type(wrp_snap_type), .cnt_pkt_total(wrp_total),
    .cnt_beats(wrp_beats), .cnt_stall(wrp_stall), .cnt_proto_err(wrp_err),
    .snap_valid(wrp_snap_valid), .dw_mem_write(wrp_dw)
  );

  pcie_cq_type_stats #(.SOP_MODE(1)) dut_md1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(md1_tready),
    .m_axis_tdata(md1_tdata), .m_axis_tkeep(md1_tkeep), .m_axis_tvalid(md1_tvalid),
    .m_axis_tlast(md1_tlast), .m_axis_tuser(md1_tuser), .m_axis_tready(m_tready),
    .clear_req(clear_req), .snap_req(snap_req),
    .cnt_type(md1_cnt_type), .snap_type(md1_snap_type), .cnt_pkt_total(md1_total),
    .cnt_beats(md1_beats), .cnt_stall(md1_stall), .cnt_proto_err(md1_err),
    .snap_valid(md1_snap_valid), .dw_mem_write(md1_dw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_beat(input logic v, input logic l, input logic [1:0] sp,
                          input logic [3:0] t, input logic [10:0] dwc);
    for (int i = 0; i < 16; i++) s_tdata[i*32 +: 32] = $urandom();
    for (int i = 0; i < 229; i++) s_tuser[i] = 1'($urandom_range(0, 1));
    s_tdata[75 +: 4]  = t;
    s_tdata[64 +: 11] = dwc;
    s_tuser[80 +: 2]  = sp;
    s_tkeep  = 16'($urandom());
    s_tvalid = v;
    s_tlast  = l;
  endtask

  // Checks the combinational mirror mid-cycle, then advances to 1ns after the next edge.
  task automatic cycle();
    #1;
    n_cmp++;
    if ({m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser, tready} !==
        {s_tdata, s_tkeep, s_tvalid, s_tlast, s_tuser, m_tready}) begin
      n_bad++;
      $display("FAIL mirror: got valid=%b last=%b ready=%b keep=%h expected valid=%b last=%b ready=%b keep=%h",
               m_tvalid, m_tlast, tready, m_tkeep, s_tvalid, s_tlast, m_tready, s_tkeep);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_beat(1'b0, 1'b0, 2'b00, 4'd0, 11'd0);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req = 1'b0;
    snap_req = 1'b0;
    m_tready = 1'b1;
    set_beat(1'b0, 1'b0, 2'b00, 4'd0, 11'd0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] typ;
    logic [1:0] sop;
    int         exp_type;
    int         exp_total;
    int         exp_beats;
  } t1_vec_t;

  t1_vec_t t1 [4];

  initial begin
    t1[0] = '{typ: 4'd0, sop: 2'b01, exp_type: 1, exp_total: 1, exp_beats: 1};
    t1[1] = '{typ: 4'd1, sop: 2'b01, exp_type: 1, exp_total: 2, exp_beats: 2};
    t1[2] = '{typ: 4'd1, sop: 2'b10, exp_type: 2, exp_total: 3, exp_beats: 3};
    t1[3] = '{typ: 4'd8, sop: 2'b11, exp_type: 1, exp_total: 4, exp_beats: 4};

    rst = 1'b1;
    do_reset();
    chk("reset total", total, 0);
    chk("reset beats", beats, 0);
    chk("reset type0", cnt_type[0 +: 32], 0);
    chk("reset snap_valid", snap_valid, 0);
    chk("reset dw", dw, 0);

    // 1: single-beat TLPs of types 0,1,1,8 (last one straddled)
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b1, 1'b1, t1[i].sop, t1[i].typ, 11'd1);
      cycle();
      $display("t1 vec %0d: type=%0d cnt=%0d total=%0d beats=%0d", i, t1[i].typ,
               cnt_type[t1[i].typ*32 +: 32], total, beats);
      chk("t1 type cnt", cnt_type[t1[i].typ*32 +: 32], t1[i].exp_type);
      chk("t1 total", total, t1[i].exp_total);
      chk("t1 beats", beats, t1[i].exp_beats);
    end
    chk("t1 type0", cnt_type[0 +: 32], 1);
    chk("t1 type1", cnt_type[32 +: 32], 2);
    chk("t1 type8", cnt_type[8*32 +: 32], 1);
    chk("t1 err", err, 0);

    // 2: 3-beat memwrite, 5 backpressure cycles mid-packet
    do_reset();
    set_beat(1'b1, 1'b0, 2'b01, 4'd1, 11'd3);
    cycle();
    set_beat(1'b1, 1'b0, 2'b00, 4'd5, 11'd0);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    m_tready = 1'b1;
    cycle();
    set_beat(1'b1, 1'b1, 2'b00, 4'd6, 11'd0);
    cycle();
    idle();
    $display("t2: type1=%0d beats=%0d stall=%0d", cnt_type[32 +: 32], beats, stall);
    chk("t2 type1", cnt_type[32 +: 32], 1);
    chk("t2 beats", beats, 3);
    chk("t2 stall", stall, 5);
    chk("t2 total", total, 1);
    chk("t2 err", err, 0);

    // 3: 20 type-0 packets into 4-bit counters
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_beat(1'b1, 1'b1, 2'b01, 4'd0, 11'd1);
      cycle();
      if (i == 15) begin
        chk("t3 sat at 15", sat_cnt_type[0 +: 4], 15);
        chk("t3 wrap at 15", wrp_cnt_type[0 +: 4], 15);
      end
      if (i == 16) begin
        chk("t3 sat at 16", sat_cnt_type[0 +: 4], 15);
        chk("t3 wrap at 16", wrp_cnt_type[0 +: 4], 0);
      end
    end
    idle();
    $display("t3: sat=%0d wrap=%0d main=%0d", sat_cnt_type[0 +: 4], wrp_cnt_type[0 +: 4], cnt_type[0 +: 32]);
    chk("t3 sat type0", sat_cnt_type[0 +: 4], 15);
    chk("t3 wrap type0", wrp_cnt_type[0 +: 4], 4);
    chk("t3 sat total", sat_total, 15);
    chk("t3 main type0", cnt_type[0 +: 32], 20);

    // 4: framing errors (SOP_MODE 0) vs SOP_MODE 1
    do_reset();
    set_beat(1'b1, 1'b1, 2'b00, 4'd3, 11'd1);
    cycle();
    set_beat(1'b1, 1'b0, 2'b01, 4'd3, 11'd1);
    cycle();
    set_beat(1'b1, 1'b1, 2'b01, 4'd4, 11'd1);
    cycle();
    idle();
    $display("t4: err=%0d total=%0d md1_err=%0d md1_total=%0d", err, total, md1_err, md1_total);
    chk("t4 err", err, 2);
    chk("t4 total", total, 2);
    chk("t4 md1 err", md1_err, 0);
    chk("t4 md1 total", md1_total, 2);

    // 4b: reset mid-packet returns framing to IDLE
    do_reset();
    set_beat(1'b1, 1'b0, 2'b01, 4'd3, 11'd1);
    cycle();
    do_reset();
    set_beat(1'b1, 1'b1, 2'b00, 4'd3, 11'd1);
    cycle();
    idle();
    $display("t4b: err=%0d total=%0d", err, total);
    chk("t4b err", err, 1);
    chk("t4b total", total, 0);

    // 5: atomic snapshot + clear with a coincident type-2 packet
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_beat(1'b1, 1'b1, 2'b01, 4'd2, 11'd1);
      cycle();
    end
    idle();
    chk("t5 pre type2", cnt_type[64 +: 32], 7);
    chk("t5 pre snap_valid", snap_valid, 0);
    chk("t5 pre snap2", snap_type[64 +: 32], 0);
    snap_req = 1'b1;
    clear_req = 1'b1;
    set_beat(1'b1, 1'b1, 2'b01, 4'd2, 11'd1);
    cycle();
    snap_req = 1'b0;
    clear_req = 1'b0;
    $display("t5: snap2=%0d type2=%0d snap_valid=%0d", snap_type[64 +: 32], cnt_type[64 +: 32], snap_valid);
    chk("t5 snap2", snap_type[64 +: 32], 7);
    chk("t5 type2", cnt_type[64 +: 32], 1);
    chk("t5 total", total, 1);
    chk("t5 snap_valid hi", snap_valid, 1);
    idle();
    chk("t5 snap_valid lo", snap_valid, 0);
    chk("t5 snap2 held", snap_type[64 +: 32], 7);
    clear_req = 1'b1;
    idle();
    clear_req = 1'b0;
    chk("t5 clear type2", cnt_type[64 +: 32], 0);
    chk("t5 clear keeps snap", snap_type[64 +: 32], 7);

    // 6: memory-write dword accumulation
    do_reset();
    set_beat(1'b1, 1'b1, 2'b01, 4'd1, 11'd4);
    cycle();
    set_beat(1'b1, 1'b1, 2'b01, 4'd1, 11'd0);
    cycle();
    set_beat(1'b1, 1'b1, 2'b01, 4'd2, 11'd7);
    cycle();
    idle();
    $display("t6: dw=%0d sat_dw=%0d wrp_dw=%0d", dw, sat_dw, wrp_dw);
    chk("t6 dw", dw, EXP_DW);
    chk("t6 sat4 dw", sat_dw, EXP_DW_SAT4);
    chk("t6 wrap4 dw", wrp_dw, EXP_DW_WRP4);
    clear_req = 1'b1;
    set_beat(1'b1, 1'b1, 2'b01, 4'd1, 11'd5);
    cycle();
    clear_req = 1'b0;
    idle();
    chk("t6 dw clear", dw, EXP_DW_CLR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
